multi_tick_gen: RTL and testbench

//  Parametrised, fully synchronous successor to the fixed ripple-counter clock divider.

---
 rtl/multi_tick_gen.sv | 122 ++++++++++++
 tb/tb_multi_tick_gen.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/multi_tick_gen.sv
// Multi-channel programmable tick generator: NUM_CH synchronous divide channels, each producing
// a one-cycle enable tick and a square wave, plus a one-hot ring advanced by one chosen channel.

module multi_tick_gen_ch #(
    parameter int DIV_W       = 16,
    parameter int DEFAULT_DIV = 3
) (
    input  logic             clk,
    input  logic             greset,
    input  logic             en,
    input  logic             sync,
    input  logic             load_hit,
    input  logic [DIV_W-1:0] load_div,
    output logic             tick_set,
    output logic             tick,
    output logic             sq
);
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;
    logic             sq_q, sq_d;

    always_comb begin
        div_d  = div_q;
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        sq_d   = sq_q;
        // A load lands in div even when sync wins the counter/phase update.
        if (load_hit)
            div_d = load_div;
        if (sync) begin
            cnt_d = '0;
            sq_d  = 1'b0;
        end else if (load_hit) begin
            cnt_d = '0;
        end else if (en) begin
            if (cnt_q == div_q) begin
                cnt_d  = '0;
                tick_d = 1'b1;
                sq_d   = ~sq_q;
            end else begin
                cnt_d = cnt_q + DIV_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge greset) begin
        if (greset) begin
            div_q  <= DIV_W'(DEFAULT_DIV);
            cnt_q  <= '0;
            tick_q <= 1'b0;
            sq_q   <= 1'b0;
        end else begin
            div_q  <= div_d;
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
            sq_q   <= sq_d;
        end
    end

    assign tick_set = tick_d;
    assign tick     = tick_q;
    assign sq       = sq_q;
endmodule

module multi_tick_gen #(
    parameter int NUM_CH      = 4,
    parameter int DIV_W       = 16,
    parameter int DEFAULT_DIV = 3,
    parameter int RING_N      = 4,
    parameter int RING_CH     = 0
) (
    input  logic                    clk,
    input  logic                    greset,
    input  logic [NUM_CH-1:0]       en,
    input  logic                    sync,
    input  logic                    load,
    input  logic [$clog2(NUM_CH):0] load_ch,
    input  logic [DIV_W-1:0]        load_div,
    output logic [NUM_CH-1:0]       tick,
    output logic [NUM_CH-1:0]       sq,
    output logic [RING_N-1:0]       ring
);
    localparam int CH_W = $clog2(NUM_CH) + 1;

    logic [NUM_CH-1:0] tick_set;
    logic [RING_N-1:0] ring_q, ring_d;

    // Indices >= NUM_CH never match a channel, so such loads fall through untouched.
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        multi_tick_gen_ch #(
            .DIV_W      (DIV_W),
            .DEFAULT_DIV(DEFAULT_DIV)
        ) u_ch (
            .clk     (clk),
            .greset  (greset),
            .en      (en[g]),
            .sync    (sync),
            .load_hit(load && (load_ch == CH_W'(g))),
            .load_div(load_div),
            .tick_set(tick_set[g]),
            .tick    (tick[g]),
            .sq      (sq[g])
        );
    end

    // Ring steps on the same edge that registers the selected channel's tick.
    always_comb begin
        ring_d = ring_q;
        if (tick_set[RING_CH])
            ring_d = {ring_q[RING_N-2:0], ring_q[RING_N-1]};
    end

    always_ff @(posedge clk or posedge greset) begin
        if (greset)
            ring_q <= RING_N'(1);
        else
            ring_q <= ring_d;
    end

    assign ring = ring_q;
endmodule

// File: tb/tb_multi_tick_gen.sv
// Self-checking bench for multi_tick_gen: vector table, directed corner sequences and
// randomized traffic compared against an enabled-edge-count reference model.

module tb_multi_tick_gen;
    localparam int NUM_CH  = 4;
    localparam int DIV_W   = 16;
    localparam int DEF_DIV = 3;
    localparam int RING_N  = 4;
    localparam int RING_CH = 0;

    logic              clk, greset, sync, load;
    logic [NUM_CH-1:0] en, tick, sq;
    logic [2:0]        load_ch;
    logic [DIV_W-1:0]  load_div;
    logic [RING_N-1:0] ring;

    int total = 0;
    int bad   = 0;

    multi_tick_gen #(
        .NUM_CH(NUM_CH), .DIV_W(DIV_W), .DEFAULT_DIV(DEF_DIV), .RING_N(RING_N), .RING_CH(RING_CH)
    ) dut (
        .clk(clk), .greset(greset), .en(en), .sync(sync), .load(load),
        .load_ch(load_ch), .load_div(load_div), .tick(tick), .sq(sq), .ring(ring)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: count enabled edges since the last restart; ticks fall on multiples of div+1,
    // sq is the phase-base XOR the parity of completed periods, ring is 1 << (ticks mod RING_N).
    longint me [NUM_CH];
    int     md [NUM_CH];
    bit     msb[NUM_CH];
    bit     mt [NUM_CH];
    int     mnt;

    task automatic model_reset();
        for (int i = 0; i < NUM_CH; i++) begin
            me[i] = 0; md[i] = DEF_DIV; msb[i] = 1'b0; mt[i] = 1'b0;
        end
        mnt = 0;
    endtask

    function automatic bit msq(int i);
        return msb[i] ^ bit'((me[i] / longint'(md[i] + 1)) & 1);
    endfunction

    task automatic model_edge(input logic [3:0] e, input logic sy, ld, input logic [2:0] c,
                              input logic [15:0] v);
        for (int i = 0; i < NUM_CH; i++) begin
            bit hit, cur;
            hit = ld && (int'(c) == i);
            cur = msq(i);
            if (sy) begin
                msb[i] = 1'b0; me[i] = 0; mt[i] = 1'b0;
            end else if (hit) begin
                msb[i] = cur; me[i] = 0; mt[i] = 1'b0;
            end else if (!e[i]) begin
                mt[i] = 1'b0;
            end else begin
                me[i]++;
                mt[i] = (me[i] % longint'(md[i] + 1)) == 0;
            end
            if (hit) md[i] = int'(v);
        end
        if (mt[RING_CH]) mnt++;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step(input logic [3:0] e, input logic sy, ld, input logic [2:0] c,
                        input logic [15:0] v);
        logic [3:0] et, es, er;
        en = e; sync = sy; load = ld; load_ch = c; load_div = v;
        @(posedge clk);
        model_edge(e, sy, ld, c, v);
        #1;
        for (int i = 0; i < NUM_CH; i++) begin
            et[i] = mt[i];
            es[i] = msq(i);
        end
        er = 4'(1 << (mnt % RING_N));
        chk("model_tick", tick, et);
        chk("model_sq", sq, es);
        chk("model_ring", ring, er);
    endtask

    typedef struct {
        logic [3:0]  en;
        logic        ld;
        logic [2:0]  ch;
        logic [15:0] dv;
        logic [3:0]  t, s, r;
    } vec_t;

    function automatic vec_t mk(logic [3:0] e, logic ld, logic [2:0] ch, logic [15:0] dv,
                                logic [3:0] t, logic [3:0] s, logic [3:0] r);
        vec_t x;
        x.en = e; x.ld = ld; x.ch = ch; x.dv = dv; x.t = t; x.s = s; x.r = r;
        return x;
    endfunction

    vec_t vecs[$];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // ch0 at default div=3: tick on enabled edges 4,8,12,16; ring walks one step per tick
        for (int k = 1; k <= 16; k++)
            vecs.push_back(mk(4'b0001, 1'b0, 3'd0, 16'd0,
                (k % 4 == 0) ? 4'b0001 : 4'b0000,
                ((k / 4) % 2 == 1) ? 4'b0001 : 4'b0000,
                4'(1 << ((k / 4) % 4))));
        vecs.push_back(mk(4'b0000, 1'b1, 3'd4, 16'd0, 4'b0000, 4'b0000, 4'b0001));
        vecs.push_back(mk(4'b0000, 1'b1, 3'd2, 16'd0, 4'b0000, 4'b0000, 4'b0001));
        vecs.push_back(mk(4'b0100, 1'b0, 3'd0, 16'd0, 4'b0100, 4'b0100, 4'b0001));
        vecs.push_back(mk(4'b0100, 1'b0, 3'd0, 16'd0, 4'b0100, 4'b0000, 4'b0001));
        vecs.push_back(mk(4'b0100, 1'b0, 3'd0, 16'd0, 4'b0100, 4'b0100, 4'b0001));

        greset = 1'b1; en = '0; sync = 1'b0; load = 1'b0; load_ch = '0; load_div = '0;
        model_reset();
        #12;
        chk("reset_out", {tick, sq, ring}, 12'h001);
        greset = 1'b0;

        for (int n = 0; n < 20; n++) begin
            step(4'b0000, 1'b0, 1'b0, 3'd0, 16'd0);
            chk("idle_out", {tick, sq, ring}, 12'h001);
        end

        foreach (vecs[k]) begin
            step(vecs[k].en, 1'b0, vecs[k].ld, vecs[k].ch, vecs[k].dv);
            chk($sformatf("vec%0d", k), {tick, sq, ring}, {vecs[k].t, vecs[k].s, vecs[k].r});
        end

        // Reload ch1 mid-count: next tick exactly 10 enabled edges later, then every 10
        step(4'b0000, 1'b1, 1'b0, 3'd0, 16'd0);
        step(4'b0010, 1'b0, 1'b0, 3'd0, 16'd0);
        step(4'b0010, 1'b0, 1'b0, 3'd0, 16'd0);
        step(4'b0010, 1'b0, 1'b1, 3'd1, 16'd9);
        chk("reload_tick0", tick[1], 1'b0);
        for (int n = 1; n <= 20; n++) begin
            step(4'b0010, 1'b0, 1'b0, 3'd0, 16'd0);
            chk($sformatf("reload_n%0d", n), tick[1], (n % 10) == 0);
        end

        // Out-of-range load ignored: ch0 still div=3, ch2 still div=0
        step(4'b0000, 1'b0, 1'b1, 3'd4, 16'd0);
        for (int n = 1; n <= 4; n++) begin
            step(4'b0101, 1'b0, 1'b0, 3'd0, 16'd0);
            chk($sformatf("badch_t0_n%0d", n), tick[0], n == 4);
            chk($sformatf("badch_t2_n%0d", n), tick[2], 1'b1);
        end

        // Sync realigns ch0 (div3) and ch3 (div5); they coincide again 12 cycles later
        step(4'b0000, 1'b0, 1'b1, 3'd3, 16'd5);
        for (int n = 0; n < 3; n++) step(4'b1001, 1'b0, 1'b0, 3'd0, 16'd0);
        step(4'b1001, 1'b1, 1'b0, 3'd0, 16'd0);
        chk("sync_clear", {tick[3], tick[0], sq[3], sq[0]}, 4'b0000);
        for (int n = 1; n <= 12; n++) begin
            step(4'b1001, 1'b0, 1'b0, 3'd0, 16'd0);
            chk($sformatf("sync_n%0d", n), {tick[3], tick[0]}, {n % 6 == 0, n % 4 == 0});
        end

        // Enable gap of 5 cycles delays the tick by exactly 5
        step(4'b0000, 1'b1, 1'b0, 3'd0, 16'd0);
        for (int n = 1; n <= 9; n++) begin
            step((n <= 2 || n >= 8) ? 4'b0001 : 4'b0000, 1'b0, 1'b0, 3'd0, 16'd0);
            chk($sformatf("gap_n%0d", n), tick[0], n == 9);
        end

        // Async reset mid-count: immediate return to reset values, div back to default
        step(4'b0000, 1'b0, 1'b1, 3'd0, 16'd9);
        for (int n = 0; n < 3; n++) step(4'b0001, 1'b0, 1'b0, 3'd0, 16'd0);
        greset = 1'b1;
        model_reset();
        #2;
        chk("midreset_out", {tick, sq, ring}, 12'h001);
        #2;
        greset = 1'b0;
        for (int n = 1; n <= 4; n++) begin
            step(4'b0001, 1'b0, 1'b0, 3'd0, 16'd0);
            chk($sformatf("postreset_n%0d", n), tick[0], n == 4);
        end

        for (int n = 0; n < 500; n++)
            step(4'($urandom_range(0, 15)), $urandom_range(0, 29) == 0, $urandom_range(0, 9) == 0,
                 3'($urandom_range(0, 7)), 16'($urandom_range(0, 6)));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
